// File: rtl/montgomery_mul_hs.sv
// montgomery_mul_hs: radix-2 bit-serial Montgomery multiplier, result = a*b*2^-WIDTH mod n.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   start  - request, accepted on an edge where start=1 and ready=1
//   abort  - synchronous cancel of an in-flight operation (ignored in IDLE)
//   a,b,n  - multiplicand, multiplier, odd modulus; sampled on the accepting edge
//   ready  - high while idle
//   done   - one-cycle pulse; result valid from this cycle
//   result - product, held until the next done
//   err    - operand-check flag (0 unless MONT_OPERAND_CHECK_EN is defined)
// Optional feature macro: MONT_OPERAND_CHECK_EN (rejects even n, a>=n, b>=n with result 0).
module montgomery_mul_hs #(
  parameter int unsigned WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned ACC_W = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, n_q;
  logic [ACC_W-1:0] s_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept_c, last_c, chk_fail_c;
  logic [ACC_W-1:0] n_ext_c, t_c, u_c, s_nxt_c;

  assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

  // One Montgomery step at full accumulator width; a_q is shifted so bit 0 is A[i].
  always_comb begin
    n_ext_c = ACC_W'(n_q);
    t_c     = s_q + (a_q[0] ? ACC_W'(b_q) : '0);
    u_c     = t_c + (t_c[0] ? n_ext_c : '0);
    s_nxt_c = u_c >> 1;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_c  = 1'b1;
          state_nxt = chk_fail_c ? FINAL : ITER;
        end
      end
      ITER: begin
        if (abort)       state_nxt = IDLE;
        else if (last_c) state_nxt = FINAL;
      end
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; ready is registered from the next state so it tracks IDLE exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ready <= 1'b1;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == IDLE);
    end
  end

  // Operand capture, iteration datapath and final conditional subtraction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      s_q    <= '0;
      cnt_q  <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_c) begin
        a_q   <= a;
        b_q   <= b;
        n_q   <= n;
        s_q   <= '0;
        cnt_q <= '0;
      end else if (state == ITER && !abort) begin
        s_q   <= s_nxt_c;
        a_q   <= a_q >> 1;
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (state == FINAL && !abort) begin
        result <= (s_q >= n_ext_c) ? WIDTH'(s_q - n_ext_c) : WIDTH'(s_q);
        done   <= 1'b1;
      end
    end
  end

`ifdef MONT_OPERAND_CHECK_EN
  // A failing check skips the iterations; S stays 0 so FINAL yields result 0.
  assign chk_fail_c = ~n[0] | (a >= n) | (b >= n);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        err <= 1'b0;
    else if (accept_c) err <= chk_fail_c;
  end
`else
  assign chk_fail_c = 1'b0;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_montgomery_mul_hs.sv
// tb_montgomery_mul_hs: randomized bench for montgomery_mul_hs (WIDTH=8 and WIDTH=256 instances)
// against a behavioural model built on a*b mod n followed by repeated modular halving.
module tb_montgomery_mul_hs;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       s8 = 1'b0, ab8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, n8 = '0;
  logic       r8, d8, e8;
  logic [7:0] res8;

  // WIDTH=256 instance
  logic         s256 = 1'b0, ab256 = 1'b0;
  logic [255:0] a256 = '0, b256 = '0, n256 = '0;
  logic         r256, d256, e256;
  logic [255:0] res256;

  int vectors     = 0;
  int miscompares = 0;

  montgomery_mul_hs #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst_n), .start(s8), .abort(ab8),
    .a(a8), .b(b8), .n(n8),
    .ready(r8), .done(d8), .result(res8), .err(e8)
  );

  montgomery_mul_hs #(.WIDTH(256)) dut256 (
    .clk(clk), .reset(rst_n), .start(s256), .abort(ab256),
    .a(a256), .b(b256), .n(n256),
    .ready(r256), .done(d256), .result(res256), .err(e256)
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // a*b*2^-w mod n: reduce the plain product, then halve modulo n w times.
  function automatic logic [511:0] mont_ref(input logic [511:0] x, input logic [511:0] y,
                                            input logic [511:0] m, input int w);
    logic [511:0] v;
    v = (x * y) % m;
    for (int k = 0; k < w; k++) begin
      if (v[0]) v = v + m;
      v = v >> 1;
    end
    return v;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Cycle-level model of the WIDTH=8 instance: m_left counts edges until done (0 = idle).
  int         m_left = 0;
  logic       m_done = 1'b0, m_err = 1'b0, m_chk;
  logic [7:0] m_res = '0, m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_err = 1'b0; m_res = '0; m_pend = '0;
    end else begin
      m_done = 1'b0;
      if (m_left == 0) begin
        if (s8) begin
`ifdef MONT_OPERAND_CHECK_EN
          m_chk = (n8[0] == 1'b0) || (a8 >= n8) || (b8 >= n8);
`else
          m_chk = 1'b0;
`endif
          m_err  = m_chk;
          m_pend = m_chk ? 8'd0 : 8'(mont_ref(512'(a8), 512'(b8), 512'(n8), 8));
          m_left = m_chk ? 1 : 9;
        end
      end else if (ab8) begin
        m_left = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_res  = m_pend;
        end
      end
    end
  end

  // Per-cycle comparison of the WIDTH=8 instance against the model.
  always @(negedge clk) begin
    check("ready8", 512'(r8), 512'(m_left == 0));
    check("done8", 512'(d8), 512'(m_done));
    check("result8", 512'(res8), 512'(m_res));
    check("err8", 512'(e8), 512'(m_err));
  end

  // Present operands with start for one edge, then scramble the inputs.
  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] in_);
    a8 = ia; b8 = ib; n8 = in_; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); n8 = 8'($urandom);
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    while (d8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (d8 !== 1'b1) check("timeout8", 512'(0), 512'(1));
  endtask

  task automatic run256(input logic [255:0] ia, input logic [255:0] ib, input logic [255:0] in_);
    logic [255:0] exp;
    int k;
    exp = 256'(mont_ref(512'(ia), 512'(ib), 512'(in_), 256));
    @(negedge clk);
    a256 = ia; b256 = ib; n256 = in_; s256 = 1'b1;
    @(negedge clk);
    s256 = 1'b0;
    a256 = rand256(); b256 = rand256();
    k = 0;
    while (d256 !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("latency256", 512'(k), 512'(257));
    check("result256", 512'(res256), 512'(exp));
    check("below_n256", 512'(res256 < in_), 512'(1));
  endtask

  initial begin
    int lat;
    logic [255:0] rn, ra, rb;

    repeat (2) @(negedge clk);
    check("rst_ready", 512'(r8), 512'(1));
    check("rst_done", 512'(d8), 512'(0));
    check("rst_result", 512'(res8), 512'(0));
    check("rst_err", 512'(e8), 512'(0));
    rst_n = 1'b1;

    // Hand-computed anchors for the model.
    check("ref_5_7_13", mont_ref(512'(5), 512'(7), 512'(13), 8), 512'(1));
    check("ref_12_12_13", mont_ref(512'(12), 512'(12), 512'(13), 8), 512'(3));

    // Basic op and back-to-back issue in the done cycle.
    @(negedge clk);
    issue8(8'd5, 8'd7, 8'd13);
    wait_done8(lat);
    check("latency_first", 512'(lat), 512'(9));
    check("result_first", 512'(res8), 512'(1));
    check("ready_in_done", 512'(r8), 512'(1));
    issue8(8'd12, 8'd12, 8'd13);
    check("held_result", 512'(res8), 512'(1));
    wait_done8(lat);
    check("latency_b2b", 512'(lat), 512'(9));
    check("result_b2b", 512'(res8), 512'(3));

    // Abort four edges after acceptance; a simultaneous start is ignored.
    @(negedge clk);
    issue8(8'd5, 8'd7, 8'd13);
    repeat (3) @(negedge clk);
    ab8 = 1'b1; s8 = 1'b1; a8 = 8'd12; b8 = 8'd12; n8 = 8'd13;
    @(negedge clk);
    ab8 = 1'b0; s8 = 1'b0;
    check("abort_ready", 512'(r8), 512'(1));
    check("abort_done", 512'(d8), 512'(0));
    check("abort_result", 512'(res8), 512'(3));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done", 512'(d8), 512'(0));
    end

    // Asynchronous reset between edges mid-iteration.
    issue8(8'd12, 8'd12, 8'd13);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", 512'(r8), 512'(1));
    check("async_rst_done", 512'(d8), 512'(0));
    check("async_rst_result", 512'(res8), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue8(8'd5, 8'd7, 8'd13);
    wait_done8(lat);
    check("after_rst_result", 512'(res8), 512'(1));

`ifdef MONT_OPERAND_CHECK_EN
    @(negedge clk);
    issue8(8'd5, 8'd7, 8'd12);
    wait_done8(lat);
    check("chk_latency", 512'(lat), 512'(1));
    check("chk_err", 512'(e8), 512'(1));
    check("chk_result", 512'(res8), 512'(0));
    issue8(8'd5, 8'd7, 8'd13);
    wait_done8(lat);
    check("chk_clear_err", 512'(e8), 512'(0));
    check("chk_clear_result", 512'(res8), 512'(1));
`endif

    // Random traffic: starts while busy, aborts and back-to-back issues all checked by the model.
    for (int c = 0; c < 12000; c++) begin
      @(negedge clk);
      n8  = {7'($urandom_range(1, 127)), 1'b1};
      a8  = 8'($urandom % 32'(n8));
      b8  = 8'($urandom % 32'(n8));
      s8  = ($urandom % 2) == 0;
      ab8 = ($urandom % 40) == 0;
    end
    @(negedge clk);
    s8 = 1'b0; ab8 = 1'b0;
    repeat (12) @(negedge clk);

    // WIDTH=256: zero multiplicand, then random operands.
    rn = rand256() | 256'd1;
    rn[255] = 1'b1;
    run256(256'd0, rand256() % rn, rn);
    check("zero_a256", 512'(res256), 512'(0));
    for (int t = 0; t < 40; t++) begin
      rn = rand256() | 256'd1;
      rn[255] = 1'($urandom % 2);
      if (rn < 256'd3) rn = 256'd3;
      ra = rand256() % rn;
      rb = rand256() % rn;
      run256(ra, rb, rn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
